// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - reciprocal frequency counter reporting deci-hertz in binary and BCD
//
// Purpose:
//   Counts clk cycles spanning PERIODS rising edges of sig_in, then computes
//   f_dHz = floor(CLK_HZ*10*PERIODS / cyc) with a restoring divider
//   (one quotient bit per cycle, 40 cycles), clamps it to 99_999_999 and
//   converts it to 8 packed BCD digits by double dabble (32 cycles).
//   With no rising edge for TIMEOUT_CYC cycles a no-signal result is reported.
//
// Optional feature:
//   FREQ_METER_DEGLITCH_EN - adds a 4-sample stability filter after the
//   synchronizer; pulses or gaps shorter than 4 cycles are ignored.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   sig_in    in   measured signal, asynchronous to clk
//   f_dHz     out  [31:0] last result in deci-Hz, binary
//   digits    out  [31:0] last result as 8 BCD digits, [3:0] = tenths of Hz
//   valid     out  one-cycle pulse when f_dHz/digits update
//   no_signal out  last result came from a timeout
//   busy      out  high while dividing or converting
module freq_meter #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned PERIODS     = 16,
  parameter int unsigned TIMEOUT_CYC = 200_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sig_in,
  output logic [31:0] f_dHz,
  output logic [31:0] digits,
  output logic        valid,
  output logic        no_signal,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DIVIDE, S_CONVERT, S_DONE, S_TOUT
  } state_t;

  localparam logic [39:0] NUM       = 40'(CLK_HZ) * 40'd10 * 40'(PERIODS);
  localparam logic [39:0] Q_MAX     = 40'd99_999_999;
  localparam logic [7:0]  LAST_EDGE = 8'(PERIODS - 1);

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q, hist_q;
  logic        level, edge_det, timeout;
  logic [31:0] to_cnt_q, cyc_cnt_q, cyc_q;
  logic [7:0]  edge_cnt_q;
  logic [39:0] num_q;
  logic [31:0] rem_q;
  logic [5:0]  step_q;
  logic [31:0] q_q, bin_q, bcd_q, bcd_adj;
  logic [31:0] f_q, digits_q;
  logic        valid_q, no_signal_q;

  logic [32:0] div_trial, div_diff;
  logic        div_bit;
  logic [31:0] rem_next;
  logic [39:0] num_next;
  logic [31:0] q_clamped;

`ifdef FREQ_METER_DEGLITCH_EN
  // The filtered level follows the synchronized input only after it has
  // disagreed for 4 consecutive samples.
  logic       flt_q;
  logic [1:0] flt_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_q     <= 1'b0;
      flt_cnt_q <= 2'd0;
    end else if (sync2_q == flt_q) begin
      flt_cnt_q <= 2'd0;
    end else if (flt_cnt_q == 2'd3) begin
      flt_q     <= sync2_q;
      flt_cnt_q <= 2'd0;
    end else begin
      flt_cnt_q <= flt_cnt_q + 2'd1;
    end
  end

  assign level = flt_q;
`else
  assign level = sync2_q;
`endif

  assign edge_det = level & ~hist_q;
  assign timeout  = (to_cnt_q >= TIMEOUT_CYC);

  // Restoring division step: numerator bits shift out of num_q's MSB into
  // the remainder while quotient bits shift into its LSB, so after 40 steps
  // num_q holds the quotient.
  assign div_trial = {rem_q, num_q[39]};
  assign div_diff  = div_trial - {1'b0, cyc_q};
  assign div_bit   = ~div_diff[32];
  assign rem_next  = div_bit ? div_diff[31:0] : div_trial[31:0];
  assign num_next  = {num_q[38:0], div_bit};
  assign q_clamped = (num_next > Q_MAX) ? Q_MAX[31:0] : num_next[31:0];

  // Double dabble: add 3 to every digit >= 5 before each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 8; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (timeout)       state_d = S_TOUT;
        else if (edge_det) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (timeout)                                  state_d = S_TOUT;
        else if (edge_det && edge_cnt_q == LAST_EDGE) state_d = S_DIVIDE;
      end
      S_DIVIDE:  if (step_q == 6'd39) state_d = S_CONVERT;
      S_CONVERT: if (step_q == 6'd31) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      S_TOUT:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      hist_q      <= 1'b0;
      to_cnt_q    <= '0;
      cyc_cnt_q   <= '0;
      edge_cnt_q  <= '0;
      cyc_q       <= '0;
      num_q       <= '0;
      rem_q       <= '0;
      step_q      <= '0;
      q_q         <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      f_q         <= '0;
      digits_q    <= '0;
      valid_q     <= 1'b0;
      no_signal_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      hist_q  <= level;
      valid_q <= 1'b0;

      // Entering IDLE restarts the no-signal window so back-to-back
      // timeouts are spaced by the full window.
      if (edge_det || (state_d == S_IDLE && state_q != S_IDLE)) begin
        to_cnt_q <= '0;
      end else if ((state_q == S_IDLE || state_q == S_COUNT) && to_cnt_q != 32'hFFFF_FFFF) begin
        to_cnt_q <= to_cnt_q + 32'd1;
      end

      unique case (state_q)
        S_IDLE: begin
          if (edge_det) begin
            cyc_cnt_q  <= '0;
            edge_cnt_q <= '0;
          end
        end
        S_COUNT: begin
          cyc_cnt_q <= cyc_cnt_q + 32'd1;
          if (edge_det) edge_cnt_q <= edge_cnt_q + 8'd1;
          if (state_d == S_DIVIDE) begin
            // +1 includes the cycle of the closing edge itself.
            cyc_q  <= cyc_cnt_q + 32'd1;
            num_q  <= NUM;
            rem_q  <= '0;
            step_q <= '0;
          end
        end
        S_DIVIDE: begin
          num_q  <= num_next;
          rem_q  <= rem_next;
          step_q <= step_q + 6'd1;
          if (step_q == 6'd39) begin
            q_q    <= q_clamped;
            bin_q  <= q_clamped;
            bcd_q  <= '0;
            step_q <= '0;
          end
        end
        S_CONVERT: begin
          bcd_q  <= {bcd_adj[30:0], bin_q[31]};
          bin_q  <= {bin_q[30:0], 1'b0};
          step_q <= step_q + 6'd1;
        end
        S_DONE: begin
          f_q         <= q_q;
          digits_q    <= bcd_q;
          no_signal_q <= 1'b0;
          valid_q     <= 1'b1;
        end
        S_TOUT: begin
          f_q         <= '0;
          digits_q    <= '0;
          no_signal_q <= 1'b1;
          valid_q     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign f_dHz     = f_q;
  assign digits    = digits_q;
  assign valid     = valid_q;
  assign no_signal = no_signal_q;
  assign busy      = (state_q == S_DIVIDE) || (state_q == S_CONVERT);

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - self-checking bench for freq_meter
module tb_freq_meter;

  logic        clk = 1'b0;
  logic        rst_lo, rst_hi, sig_lo, sig_hi;
  logic [31:0] f_lo, d_lo, f_hi, d_hi;
  logic        v_lo, ns_lo, b_lo, v_hi, ns_hi, b_hi;

  always #5 clk = ~clk;

  // Low-rate instance: 1000 Hz = 220 cycles, 440 Hz = 500 cycles.
  freq_meter #(.CLK_HZ(220_000), .PERIODS(4), .TIMEOUT_CYC(1000)) dut_lo (
    .clk(clk), .rst(rst_lo), .sig_in(sig_lo), .f_dHz(f_lo), .digits(d_lo),
    .valid(v_lo), .no_signal(ns_lo), .busy(b_lo));

  // High-rate instance at the default clock and averaging, for clamping.
  freq_meter #(.CLK_HZ(100_000_000), .PERIODS(16), .TIMEOUT_CYC(1000)) dut_hi (
    .clk(clk), .rst(rst_hi), .sig_in(sig_hi), .f_dHz(f_hi), .digits(d_hi),
    .valid(v_hi), .no_signal(ns_hi), .busy(b_hi));

  typedef struct {
    logic [31:0] f;
    logic [31:0] dig;
    logic        ns;
  } res_t;

  typedef struct {
    bit          hi;
    int          period;
    int          high;
    int          gat;
    int          glen;
    int          nres;
    logic [31:0] f;
    logic [31:0] dig;
  } vec_t;

  res_t q_lo[$];
  res_t q_hi[$];
  res_t r_push;
  vec_t vecs[10];

  int n_checks = 0;
  int n_err = 0;
  int popped_lo = 0;
  int popped_hi = 0;
  int w_period, w_high, w_gat, w_glen, ph;

  int   blen_lo = 0, gap_lo = 0, blen_hi = 0, gap_hi = 0;
  logic bprev_lo = 1'b0, bprev_hi = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  task automatic score(input bit hi, input logic [31:0] f, input logic [31:0] d,
                       input logic ns, input int blen, input int gap);
    res_t  e;
    string tag;
    int    sz;
    tag = hi ? "hi" : "lo";
    if (hi) begin popped_hi++; sz = q_hi.size(); end
    else begin popped_lo++; sz = q_lo.size(); end
    if (sz == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_unexpected_valid: got valid with f_dHz=%0d, expected no result", tag, f);
      return;
    end
    if (hi) e = q_hi.pop_front();
    else e = q_lo.pop_front();
    chk({tag, "_f_dHz"}, f, e.f);
    chk({tag, "_digits"}, d, e.dig);
    chk({tag, "_no_signal"}, {31'd0, ns}, {31'd0, e.ns});
    if (!e.ns) begin
      chk({tag, "_busy_len"}, 32'(blen), 32'd72);
      chk({tag, "_busy_to_valid"}, 32'(gap), 32'd2);
    end
  endtask

  // Scoreboard monitors: track busy run length and the gap to valid.
  always @(negedge clk) begin
    if (b_lo) begin
      if (!bprev_lo) blen_lo = 0;
      blen_lo++;
      gap_lo = 0;
    end else gap_lo++;
    bprev_lo = b_lo;
    if (v_lo) score(1'b0, f_lo, d_lo, ns_lo, blen_lo, gap_lo);
  end

  always @(negedge clk) begin
    if (b_hi) begin
      if (!bprev_hi) blen_hi = 0;
      blen_hi++;
      gap_hi = 0;
    end else gap_hi++;
    bprev_hi = b_hi;
    if (v_hi) score(1'b1, f_hi, d_hi, ns_hi, blen_hi, gap_hi);
  end

  task automatic reset_all(input bit hi);
    @(negedge clk);
    rst_lo = 1'b1;
    rst_hi = 1'b1;
    sig_lo = 1'b0;
    sig_hi = 1'b0;
    q_lo.delete();
    q_hi.delete();
    repeat (3) @(negedge clk);
    if (hi) rst_hi = 1'b0;
    else rst_lo = 1'b0;
    ph = 0;
  endtask

  task automatic wave_step(input bit hi);
    logic s;
    @(negedge clk);
    s = (ph < w_high) && !(ph >= w_gat && ph < w_gat + w_glen);
    if (hi) sig_hi = s;
    else sig_lo = s;
    ph = (ph + 1 == w_period) ? 0 : ph + 1;
  endtask

  task automatic wait_pops(input bit hi, input int target, input int budget, input string name);
    int n;
    n = 0;
    while ((hi ? popped_hi : popped_lo) < target && n < budget) begin
      wave_step(hi);
      n++;
    end
    if ((hi ? popped_hi : popped_lo) < target) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_no_result: results %0d after %0d cycles, required %0d",
               name, hi ? popped_hi : popped_lo, n, target);
    end
  endtask

  task automatic set_wave(input int period, input int high, input int gat, input int glen);
    w_period = period;
    w_high   = high;
    w_gat    = gat;
    w_glen   = glen;
    ph       = 0;
  endtask

  initial begin
    int c;
    int n;
    int base;

    vecs[0] = '{1'b0, 220, 110, 0, 0, 2, 32'd10000, 32'h0001_0000};
    vecs[1] = '{1'b0, 500, 250, 0, 0, 1, 32'd4400, 32'h0000_4400};
    vecs[2] = '{1'b0, 333, 100, 0, 0, 1, 32'd6606, 32'h0000_6606};
`ifdef FREQ_METER_DEGLITCH_EN
    vecs[3] = '{1'b0, 220, 110, 55, 2, 1, 32'd10000, 32'h0001_0000};
    vecs[4] = '{1'b1, 8, 4, 0, 0, 1, 32'd99_999_999, 32'h9999_9999};
`else
    vecs[3] = '{1'b0, 220, 110, 55, 2, 1, 32'd20000, 32'h0002_0000};
    vecs[4] = '{1'b1, 5, 2, 0, 0, 1, 32'd99_999_999, 32'h9999_9999};
`endif
    vecs[5] = '{1'b1, 10, 5, 0, 0, 1, 32'd99_999_999, 32'h9999_9999};
    vecs[6] = '{1'b1, 11, 5, 0, 0, 1, 32'd90_909_090, 32'h9090_9090};
    vecs[7] = '{1'b1, 16, 8, 0, 0, 1, 32'd62_500_000, 32'h6250_0000};
    vecs[8] = '{1'b1, 17, 8, 0, 0, 1, 32'd58_823_529, 32'h5882_3529};
    vecs[9] = '{1'b1, 999, 500, 0, 0, 1, 32'd1_001_001, 32'h0100_1001};

    rst_lo = 1'b1;
    rst_hi = 1'b1;
    sig_lo = 1'b0;
    sig_hi = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_lo_f_dHz", f_lo, 32'd0);
    chk("rst_lo_digits", d_lo, 32'd0);
    chk("rst_lo_valid", {31'd0, v_lo}, 32'd0);
    chk("rst_lo_no_signal", {31'd0, ns_lo}, 32'd1);
    chk("rst_lo_busy", {31'd0, b_lo}, 32'd0);
    chk("rst_hi_f_dHz", f_hi, 32'd0);
    chk("rst_hi_digits", d_hi, 32'd0);
    chk("rst_hi_valid", {31'd0, v_hi}, 32'd0);
    chk("rst_hi_no_signal", {31'd0, ns_hi}, 32'd1);
    chk("rst_hi_busy", {31'd0, b_hi}, 32'd0);

    foreach (vecs[i]) begin
      reset_all(vecs[i].hi);
      set_wave(vecs[i].period, vecs[i].high, vecs[i].gat, vecs[i].glen);
      r_push.f   = vecs[i].f;
      r_push.dig = vecs[i].dig;
      r_push.ns  = 1'b0;
      for (int k = 0; k < vecs[i].nres; k++) begin
        if (vecs[i].hi) q_hi.push_back(r_push);
        else q_lo.push_back(r_push);
      end
      base = vecs[i].hi ? popped_hi : popped_lo;
      wait_pops(vecs[i].hi, base + vecs[i].nres,
                vecs[i].nres * ((vecs[i].hi ? 16 : 4) + 2) * vecs[i].period + 400,
                $sformatf("vec%0d", i));
    end

    // No signal after reset: timeout result at cycle 1002, then every 1002.
    reset_all(1'b0);
    r_push = '{f: 32'd0, dig: 32'd0, ns: 1'b1};
    q_lo.push_back(r_push);
    q_lo.push_back(r_push);
    c = 0;
    while (c < 1100) begin
      @(negedge clk);
      c++;
      if (v_lo) break;
    end
    chk("tout_first_valid_cycle", 32'(c), 32'd1002);
    c = 0;
    while (c < 1100) begin
      @(negedge clk);
      c++;
      if (v_lo) break;
    end
    chk("tout_repeat_cycles", 32'(c), 32'd1002);

    // Reset during DIVIDE aborts; the next measurement completes normally.
    reset_all(1'b0);
    set_wave(220, 110, 0, 0);
    q_lo.push_back('{f: 32'd10000, dig: 32'h0001_0000, ns: 1'b0});
    wait_pops(1'b0, popped_lo + 1, 2000, "pre_abort");
    n = 0;
    while (!b_lo && n < 3000) begin
      wave_step(1'b0);
      n++;
    end
    chk("abort_busy_seen", {31'd0, b_lo}, 32'd1);
    repeat (19) wave_step(1'b0);
    rst_lo = 1'b1;
    #1;
    chk("abort_f_dHz", f_lo, 32'd0);
    chk("abort_digits", d_lo, 32'd0);
    chk("abort_valid", {31'd0, v_lo}, 32'd0);
    chk("abort_no_signal", {31'd0, ns_lo}, 32'd1);
    chk("abort_busy", {31'd0, b_lo}, 32'd0);
    sig_lo = 1'b0;
    repeat (2) @(negedge clk);
    rst_lo = 1'b0;
    set_wave(220, 110, 0, 0);
    q_lo.push_back('{f: 32'd10000, dig: 32'h0001_0000, ns: 1'b0});
    wait_pops(1'b0, popped_lo + 1, 2000, "post_abort");

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
